imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It decodes all RV32I/RV64I immediate formats (I, shift-imm, S, B, U, J) and sign-extends to XLEN. The result passes through STAGES registered slots with valid/ready handshake, backpressure, and flush. A sidecar tag (normally the PC) travels with each instruction. It sits between IF/ID and the ID/EX register.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
STAGES, 1, number of register slots (legal 1..4); this is also the latency in cycles.
TAG_W, 32, width of the sidecar tag carried with each instruction.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous reset, active-low
flush_i  input  1  synchronous kill of every in-flight entry
in_valid_i  input  1  instr_i/tag_i are presented
in_ready_o  output  1  block accepts an input this cycle
instr_i  input  32  raw instruction word
tag_i  input  TAG_W  sidecar data (PC)
out_valid_o  output  1  output slot holds a valid entry
out_ready_i  input  1  consumer accepts the output this cycle
immediate_o  output  XLEN  decoded, sign-extended immediate
fmt_o  output  3  format: 0 NONE, 1 I, 2 SHIFT, 3 S, 4 B, 5 U, 6 J
illegal_o  output  1  opcode carries no immediate (fmt NONE)
tag_o  output  TAG_W  tag of the output entry

Behaviour:
- Decode is combinational on instr_i and is captured into slot 0. Later slots only move data.
- Opcode 0010011 with funct3 001 or 101 → SHIFT. Immediate is the zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. The funct7/funct6 bits are excluded.
- Opcode 0010011 (other funct3), opcode 0000011, and opcode 1100111 with funct3=000 → I: sext(instr[31:20]).
- Opcode 0100011 → S: sext({instr[31:25], instr[11:7]}).
- Opcode 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). Bit 0 is always 0.
- Opcode 0110111 or 0010111 → U: sext({instr[31:12], 12'b0}).
- Opcode 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other opcode → immediate 0, fmt 0, illegal 1. Such entries still flow through the pipe.
- Sign extension is always from instr[31] to the full XLEN.
- Per-slot handshake, with slots k = 0..STAGES-1 and v[k] the valid bit of slot k:
  - rdy[STAGES] = out_ready_i.
  - rdy[k] = !v[k] || rdy[k+1]. The ready chain is combinational.
  - in_ready_o = rdy[0].
- Transfer into slot k occurs when rdy[k] is high and the upstream entry is valid.
- Full throughput: one entry per cycle when out_ready_i is held high.
- Latency: an input accepted at edge N appears on the outputs after edge N+STAGES-1, i.e. STAGES cycles from presentation.
- Stall: a slot's data and valid bit hold while v[k] && !rdy[k+1]. While out_valid_o && !out_ready_i, every output is stable.
- Full condition: all slots valid and out_ready_i low → in_ready_o low. An input held in that state is not lost; it is accepted once ready rises.
- Flush: all v[k] clear at the next edge. An input presented in the flush cycle is discarded even if in_ready_o is high. Flush has priority over simultaneous accept and transfer.
- Data registers update only on transfer. Dropping a valid bit does not clear data, except at reset.
- Reset (rst_i low, asynchronous, may occur mid-stream): all v[k] go to 0, and all data, fmt, illegal and tag registers go to 0. Output reset values are out_valid_o 0, immediate_o 0, fmt_o 0, illegal_o 0, tag_o 0.
- in_ready_o during reset is 1 (all slots empty), but nothing is captured until rst_i is high.

Test Plan:
- STAGES=1, XLEN=32: addi 0xFFF00093, tag 0x100, out_ready 1 → next cycle out_valid 1, immediate 0xFFFFFFFF, fmt 1, tag 0x100.
- beq 0xFE000CE3 → immediate 0xFFFFFFF8, fmt 4. jal 0x001000EF → immediate 0x00000800, fmt 6.
- srai 0x4030D093 → immediate 0x00000003, fmt 2. lui 0x123452B7 → 0x12345000, fmt 5. Opcode 0110011 (add) → immediate 0, fmt 0, illegal 1.
- XLEN=64: lui 0x800002B7 → 0xFFFFFFFF80000000. slli with instr[25]=1, shamt 33 → immediate 33.
- STAGES=2: stream 4 instructions with out_ready 0 for 3 cycles → in_ready_o falls after 2 accepts. Outputs stay stable during the stall. After release, all 4 emerge in order with no duplicates or drops.
- STAGES=3, 3 entries in flight: pulse flush_i together with a new valid input → next cycle out_valid 0 and the pipe is empty; the new input never appears. Separately, assert rst_i low asynchronously mid-stream → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode into a STAGES-deep
// register pipe with valid/ready handshake, flush and a sidecar tag.

module imm_gen_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         up_vld,
  input  logic         take,
  input  logic [W-1:0] up_data,
  output logic         vld,
  output logic [W-1:0] data
);
  // take == slot empty or draining; data only moves when something real arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (take) begin
      vld <= up_vld;
      if (up_vld) data <= up_data;
    end
  end
endmodule

module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  immediate_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHIFT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [6:0]      opc;
  logic [2:0]      f3;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  entry_t          dec;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];

  always_comb begin
    fmt = FMT_NONE;
    case (opc)
      7'b0010011: fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHIFT : FMT_I;
      7'b0000011: fmt = FMT_I;
      7'b1100111: if (f3 == 3'b000) fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0110111,
      7'b0010111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      default:    fmt = FMT_NONE;
    endcase
  end

  // Signed size casts give sign extension from instr[31] to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = XLEN'($signed(instr_i[31:20]));
      FMT_SHIFT: imm = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
      FMT_S:     imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      FMT_B:     imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                      instr_i[11:8], 1'b0}));
      FMT_U:     imm = XLEN'($signed({instr_i[31:12], 12'b0}));
      FMT_J:     imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                      instr_i[30:21], 1'b0}));
      default:   imm = '0;
    endcase
  end

  assign dec = '{imm: imm, fmt: fmt, illegal: (fmt == FMT_NONE), tag: tag_i};

  logic [STAGES-1:0]         slot_vld;
  logic [STAGES-1:0][EW-1:0] slot_data;
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0]           rdy;
  entry_t                    out_e;

  assign vld_pipe = {slot_vld, in_valid_i};

  // Ready ripples back from the consumer through every empty slot.
  always_comb begin
    rdy[STAGES] = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !slot_vld[k] || rdy[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic [EW-1:0] up;
    if (k == 0) begin : g_head
      assign up = dec;
    end else begin : g_body
      assign up = slot_data[k-1];
    end
    imm_gen_slot #(.W(EW)) u_slot (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .flush   (flush_i),
      .up_vld  (vld_pipe[k]),
      .take    (rdy[k]),
      .up_data (up),
      .vld     (slot_vld[k]),
      .data    (slot_data[k])
    );
  end

  assign out_e       = entry_t'(slot_data[STAGES-1]);
  assign in_ready_o  = rdy[0];
  assign out_valid_o = vld_pipe[STAGES];
  assign immediate_o = out_e.imm;
  assign fmt_o       = out_e.fmt;
  assign illegal_o   = out_e.illegal;
  assign tag_o       = out_e.tag;
endmodule
